cpu_clock_control: RTL and testbench

Run/stop/single-step controller that sits directly downstream of `clock_divider`. It consumes the divider's slow square wave and converts each rising edge into a one-cycle clock-enable pulse for the Mini-SRC datapath, so the CPU runs on the fast board clock with a qualified enable rather than on a derived clock. It gates those pulses according to a board run switch, a debounced single-step button and the CPU's halt signal, and it counts issued enables for display.

---
 rtl/cpu_clock_control.sv | 155 +++++++++++++++
 tb/tb_cpu_clock_control.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_control.sv
// Run/stop/single-step clock-enable controller for the Mini-SRC datapath.
// Turns each rising edge of the divider's slow square wave into a one-cycle
// enable on the fast board clock, gated by a run switch, a debounced step
// button and the CPU halt line, and counts the enables it issues.
module cpu_clock_control #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic        in_clock,
  input  logic        in_reset_n,
  input  logic        in_slow_clock,
  input  logic        in_run_switch,
  input  logic        in_step_button,
  input  logic        in_halt,
  output logic        out_cpu_enable,
  output logic        out_running,
  output logic        out_halted,
  output logic [15:0] out_enable_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state;

  logic [1:0]  run_sync;
  logic [1:0]  btn_sync;
  logic        slow_d;
  logic        run_s;
  logic        btn_s;
  logic        tick;

  logic [19:0] db_count;
  logic        btn_stable;
  logic        btn_stable_d;
  logic        step_req;

  assign run_s = run_sync[1];
  assign btn_s = btn_sync[1];

  // The slow clock is already registered on in_clock, so a single delay
  // flop is enough to find its rising edge.
  assign tick = in_slow_clock & ~slow_d;

  // One-cycle pulse on the debounced press; both operands are flops.
  assign step_req = btn_stable & ~btn_stable_d;

  // Two-flop synchronizers for the raw board inputs and the slow-clock delay.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      run_sync <= 2'b00;
      btn_sync <= 2'b00;
      slow_d   <= 1'b0;
    end else begin
      run_sync <= {run_sync[0], in_run_switch};
      btn_sync <= {btn_sync[0], in_step_button};
      slow_d   <= in_slow_clock;
    end
  end

  // Step-button debounce: the stable value only follows btn_s after it has
  // differed for DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      db_count     <= 20'd0;
      btn_stable   <= 1'b0;
      btn_stable_d <= 1'b0;
    end else begin
      btn_stable_d <= btn_stable;
      if (btn_s == btn_stable) begin
        db_count <= 20'd0;
      end else if (db_count == DEBOUNCE_CYCLES - 20'd1) begin
        btn_stable <= btn_s;
        db_count   <= 20'd0;
      end else begin
        db_count <= db_count + 20'd1;
      end
    end
  end

  // Control FSM with registered status outputs, the enable pulse and the
  // enable counter. Priority: halt, then run release, then tick, then step.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state            <= IDLE;
      out_cpu_enable   <= 1'b0;
      out_running      <= 1'b0;
      out_halted       <= 1'b0;
      out_enable_count <= 16'd0;
    end else begin
      out_cpu_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (in_halt) begin
            state      <= HALTED;
            out_halted <= 1'b1;
          end else if (run_s) begin
            state       <= RUN;
            out_running <= 1'b1;
          end else if (step_req) begin
            state <= STEP;
          end
        end

        RUN: begin
          if (in_halt) begin
            state       <= HALTED;
            out_running <= 1'b0;
            out_halted  <= 1'b1;
          end else if (!run_s) begin
            state       <= IDLE;
            out_running <= 1'b0;
          end else if (tick) begin
            out_cpu_enable   <= 1'b1;
            out_enable_count <= out_enable_count + 16'd1;
          end
        end

        STEP: begin
          // A second step request or the run switch cannot cut a step short;
          // only halt pre-empts the pending enable.
          if (in_halt) begin
            state      <= HALTED;
            out_halted <= 1'b1;
          end else if (tick) begin
            state            <= IDLE;
            out_cpu_enable   <= 1'b1;
            out_enable_count <= out_enable_count + 16'd1;
          end
        end

        HALTED: begin
          // Leaving halt needs the run switch off as well, so the CPU never
          // free-runs straight out of a halt.
          if (!in_halt && !run_s) begin
            state      <= IDLE;
            out_halted <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          out_running <= 1'b0;
          out_halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_clock_control.sv
// Randomized-bounce, scoreboard-checked bench for cpu_clock_control.
// A behavioural model predicts every enable pulse (cycle and count value);
// a monitor on the falling edge pops and compares against the DUT.
module tb_cpu_clock_control;

  localparam int DEB = 4;

  logic        clk;
  logic        rst_n;
  logic        in_slow_clock;
  logic        in_run_switch;
  logic        in_step_button;
  logic        in_halt;
  logic        out_cpu_enable;
  logic        out_running;
  logic        out_halted;
  logic [15:0] out_enable_count;

  cpu_clock_control #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .in_clock         (clk),
    .in_reset_n       (rst_n),
    .in_slow_clock    (in_slow_clock),
    .in_run_switch    (in_run_switch),
    .in_step_button   (in_step_button),
    .in_halt          (in_halt),
    .out_cpu_enable   (out_cpu_enable),
    .out_running      (out_running),
    .out_halted       (out_halted),
    .out_enable_count (out_enable_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- slow clock source: divide-by-5 square wave ----------------
  bit slow_en   = 1'b1;
  bit slow_last = 1'b0;
  int div_cnt   = 0;

  initial begin
    in_slow_clock = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      slow_last = in_slow_clock;
      if (slow_en) begin
        div_cnt       = (div_cnt + 1) % 5;
        in_slow_clock = (div_cnt < 2);
      end else begin
        div_cnt       = 0;
        in_slow_clock = 1'b0;
      end
    end
  end

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_STEP, M_HALTED} mode_t;
  typedef struct {
    int          cyc;
    logic [15:0] count;
  } exp_t;

  exp_t        sb[$];
  mode_t       m_mode = M_IDLE;
  logic [15:0] m_count = '0;
  int          cyc = 0;
  bit          run_p1, run_p2, btn_p1, btn_p2, slow_prev, stable, rose;
  int          streak;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_count = '0;
      run_p1 = 0; run_p2 = 0; btn_p1 = 0; btn_p2 = 0;
      slow_prev = 0; stable = 0; rose = 0; streak = 0;
      sb.delete();
    end else begin
      bit run_now, btn_now, tick_now, step_now, fire;
      cyc++;
      // Inputs as the control logic sees them: the pins two edges ago.
      run_now  = run_p2;
      btn_now  = btn_p2;
      tick_now = in_slow_clock && !slow_prev;
      step_now = rose;
      fire     = 0;
      case (m_mode)
        M_IDLE:   if (in_halt) m_mode = M_HALTED;
                  else if (run_now) m_mode = M_RUN;
                  else if (step_now) m_mode = M_STEP;
        M_RUN:    if (in_halt) m_mode = M_HALTED;
                  else if (!run_now) m_mode = M_IDLE;
                  else fire = tick_now;
        M_STEP:   if (in_halt) m_mode = M_HALTED;
                  else if (tick_now) begin fire = 1; m_mode = M_IDLE; end
        M_HALTED: if (!in_halt && !run_now) m_mode = M_IDLE;
        default:  m_mode = M_IDLE;
      endcase
      if (fire) begin
        m_count++;
        sb.push_back('{cyc, m_count});
      end
      // Button accepted after DEB consecutive differing samples.
      rose = 0;
      if (btn_now != stable) begin
        streak++;
        if (streak == DEB) begin
          stable = btn_now;
          streak = 0;
          rose   = btn_now;
        end
      end else begin
        streak = 0;
      end
      run_p2 = run_p1; run_p1 = in_run_switch;
      btn_p2 = btn_p1; btn_p1 = in_step_button;
      slow_prev = in_slow_clock;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          en_cycles[$];
  logic [15:0] en_counts[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("enable_pulse", out_cpu_enable, 1);
        if (out_cpu_enable) check("count_at_enable", out_enable_count, e.count);
      end else begin
        check("enable_pulse", out_cpu_enable, 0);
      end
      check("running", out_running, m_mode == M_RUN);
      check("halted", out_halted, m_mode == M_HALTED);
      if (out_cpu_enable) begin
        en_cycles.push_back(cyc);
        en_counts.push_back(out_enable_count);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_run_switch = 1'b0; in_step_button = 1'b0; in_halt = 1'b0;
    step(2);
    check("rst_enable", out_cpu_enable, 0);
    check("rst_running", out_running, 0);
    check("rst_halted", out_halted, 0);
    check("rst_count", out_enable_count, 0);
    rst_n = 1'b1;
    en_cycles.delete();
    en_counts.delete();
    step(1);
  endtask

  task automatic wait_enables(input int target, input int budget, input string name);
    for (int i = 0; i < budget && en_cycles.size() < target; i++) step(1);
    check(name, en_cycles.size(), target);
  endtask

  // Returns at #2 after edge j, where the slow clock rose; edge j+1 ticks.
  task automatic wait_tick_window();
    bit found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clk);
      #2;
      found = in_slow_clock && !slow_last;
    end
    check("tick_window_found", found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    rst_n = 1'b0;
    in_run_switch = 1'b0; in_step_button = 1'b0; in_halt = 1'b0;
    step(1);

    // Free-run: 3-edge run latency, 5-cycle enable spacing, count = pulses.
    do_reset();
    in_run_switch = 1'b1;
    step(2);
    check("run_latency_2edges", out_running, 0);
    step(1);
    check("run_latency_3edges", out_running, 1);
    en_cycles.delete();
    step(50);
    check("freerun_pulses_ge9", en_cycles.size() >= 9, 1);
    for (int i = 1; i < en_cycles.size(); i++)
      check("freerun_spacing", en_cycles[i] - en_cycles[i-1], 5);
    check("freerun_count", out_enable_count, en_cycles.size());
    in_run_switch = 1'b0;
    step(5);

    // Single step with random bounce, then release and re-press.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      in_step_button = 1'b1;
      step($urandom_range(1, 2));
      in_step_button = 1'b0;
      step($urandom_range(1, 2));
    end
    in_step_button = 1'b1;
    step(10);
    wait_enables(1, 25, "step_first_enable");
    step(8);
    check("step_count_1", out_enable_count, 1);
    check("step_back_idle_running", out_running, 0);
    in_step_button = 1'b0;
    step(12);
    in_step_button = 1'b1;
    step(12);
    wait_enables(2, 25, "step_second_enable");
    step(8);
    check("step_count_2", out_enable_count, 2);
    in_step_button = 1'b0;
    step(10);

    // Halt on the same edge as a tick.
    do_reset();
    in_run_switch = 1'b1;
    step(8);
    wait_tick_window();
    in_halt = 1'b1;
    step(1);
    check("halt_tick_no_enable", out_cpu_enable, 0);
    check("halt_tick_halted", out_halted, 1);
    check("halt_tick_running", out_running, 0);
    in_halt = 1'b0;
    step(10);
    check("halt_held_by_run", out_halted, 1);
    in_run_switch = 1'b0;
    step(2);
    check("halt_exit_2edges", out_halted, 1);
    step(1);
    check("halt_exit_3edges", out_halted, 0);
    step(5);

    // Run switch falls in sync with a tick.
    do_reset();
    in_run_switch = 1'b1;
    step(8);
    wait_tick_window();
    repeat (3) @(posedge clk);
    #1;
    in_run_switch = 1'b0;
    step(3);
    check("rundrop_no_enable", out_cpu_enable, 0);
    check("rundrop_running", out_running, 0);
    check("rundrop_count", out_enable_count, m_count);
    step(5);

    // Counter wrap from a preset value.
    do_reset();
    force dut.out_enable_count = 16'hFFFE;
    m_count = 16'hFFFE;
    step(1);
    release dut.out_enable_count;
    step(1);
    in_run_switch = 1'b1;
    wait_enables(3, 40, "wrap_enables");
    in_run_switch = 1'b0;
    step(8);
    if (en_counts.size() >= 3) begin
      check("wrap_ffff", en_counts[0], 16'hFFFF);
      check("wrap_0000", en_counts[1], 16'h0000);
      check("wrap_0001", en_counts[2], 16'h0001);
    end

    // Asynchronous reset while waiting in STEP.
    do_reset();
    in_run_switch = 1'b1;
    wait_enables(2, 40, "prestep_enables");
    in_run_switch = 1'b0;
    step(5);
    slow_en = 1'b0;
    step(3);
    in_step_button = 1'b1;
    for (int i = 0; i < 30 && m_mode != M_STEP; i++) step(1);
    check("reached_step", m_mode == M_STEP, 1);
    check("prereset_count", out_enable_count, m_count);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_enable", out_cpu_enable, 0);
    check("async_rst_running", out_running, 0);
    check("async_rst_halted", out_halted, 0);
    check("async_rst_count", out_enable_count, 0);
    in_step_button = 1'b0;
    step(2);
    rst_n = 1'b1;
    slow_en = 1'b1;
    en_cycles.delete();
    step(25);
    check("post_reset_no_enable", en_cycles.size(), 0);
    check("post_reset_count", out_enable_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
